sprite_line_draw: RTL

//  Per-scanline sprite renderer that drives a 1-cycle synchronous sprite ROM and consumes its output.
//  ROM word = one sprite row, MSB = leftmost pixel; ROM depth = SPR_H*FRAMES rows.
//  On each line strobe it fetches the needed row, then emits a registered 1-bit pixel + drawing flag.

---
 rtl/sprite_line_draw.sv | 109 ++++++++++
 1 files changed

// File: rtl/sprite_line_draw.sv
// Per-scanline sprite renderer: fetches one sprite row from a 1-cycle synchronous ROM on each
// line strobe, then emits a registered pixel/drawing pair while sx crosses the sprite.
module sprite_line_draw #(
    parameter int CORDW      = 16,
    parameter int SPR_W      = 8,
    parameter int SPR_H      = 8,
    parameter int FRAMES     = 2,
    parameter int SCALE_LOG2 = 0,
    localparam int ADDRW     = $clog2(SPR_H * FRAMES),
    localparam int FRAMEW    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    input  logic [FRAMEW-1:0]       frame,
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [SPR_W-1:0]        rom_data,
    output logic                    pix,
    output logic                    drawing
);

    localparam int COLW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int ROWW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    // Scaled sprite extents, one bit wider than the coordinates so edge sums cannot overflow.
    localparam logic signed [CORDW:0] HS = (CORDW+1)'(SPR_H << SCALE_LOG2);
    localparam logic signed [CORDW:0] WS = (CORDW+1)'(SPR_W << SCALE_LOG2);

    typedef enum logic [2:0] {IDLE, MEM, LOAD, WAIT_POS, DRAW} state_t;

    state_t                  state;
    logic signed [CORDW-1:0] sprx_r;
    logic [SPR_W-1:0]        row_reg;

    logic signed [CORDW:0] sx_e, sy_e, spry_e, sprx_r_e;
    logic signed [CORDW:0] dy, dx;
    logic                  in_y, at_start, past_end;
    logic [ROWW-1:0]       row;
    logic [COLW-1:0]       col, pix_idx;
    logic [ADDRW-1:0]      fetch_addr;

    // Sign-extended coordinate arithmetic and row/column decode.
    always_comb begin
        sx_e       = {sx[CORDW-1], sx};
        sy_e       = {sy[CORDW-1], sy};
        spry_e     = {spry[CORDW-1], spry};
        sprx_r_e   = {sprx_r[CORDW-1], sprx_r};
        dy         = sy_e - spry_e;
        dx         = sx_e - sprx_r_e;
        in_y       = (sy_e >= spry_e) && (sy_e < spry_e + HS);
        at_start   = (sx_e >= sprx_r_e);
        past_end   = (sx_e >= sprx_r_e + WS);
        // dy/dx are only used when non-negative, so a logical shift is safe.
        row        = ROWW'($unsigned(dy) >> SCALE_LOG2);
        col        = COLW'($unsigned(dx) >> SCALE_LOG2);
        pix_idx    = COLW'(SPR_W - 1) - col;
        fetch_addr = ADDRW'(frame) * ADDRW'(SPR_H) + ADDRW'(row);
    end

    // Line FSM with registered ROM address and pixel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            sprx_r   <= '0;
            row_reg  <= '0;
            pix      <= 1'b0;
            drawing  <= 1'b0;
        end else begin
            pix     <= 1'b0;
            drawing <= 1'b0;
            if (line) begin
                // A strobe in any state restarts the line.
                if (in_y) begin
                    rom_addr <= fetch_addr;
                    sprx_r   <= sprx;
                    state    <= MEM;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    MEM:  state <= LOAD;
                    LOAD: begin
                        row_reg <= rom_data;
                        state   <= WAIT_POS;
                    end
                    // WAIT_POS also emits so the first column is not lost on entry to DRAW.
                    WAIT_POS, DRAW: begin
                        if (past_end) begin
                            state <= IDLE;
                        end else if (at_start) begin
                            drawing <= 1'b1;
                            pix     <= row_reg[pix_idx];
                            state   <= DRAW;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
